// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM/WB end of the pipeline.
// Holds the write-back source selector codes, the memory-access FSM state
// type and the packed bundle registered toward the WB stage.
package pipeline_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_NPC = 2'b10;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

  // Everything the WB stage and the WB->ID bypass need about one instruction
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  num_write;
    logic        reg_write;
    logic [31:0] ins;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
//   dmem_req   : access request, held until ack or abort
//   dmem_we    : 1 = store, 0 = load (valid while dmem_req)
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : store data
//   dmem_ack   : one-cycle completion pulse, dmem_rdata valid in the same cycle
//   dmem_rdata : load data
// master = pipeline side, slave = memory side.
interface mem_wb_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bubble       : capture an empty slot (all zero) instead of d
//   d            : bundle produced by the MEM stage this cycle
//   q            : registered bundle toward WB
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Loads every cycle; a bubble is a zero bundle so WB writes nothing
  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register.
// Performs the data-memory access over a req/ack handshake, stalls the
// upstream stages while an access is outstanding, aborts after TIMEOUT
// waiting cycles, and registers the selected write-back value toward WB.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   *_EXE_MEM             : EX/MEM register contents (npc, ALU result, store
//                           data, destination, store flag, WB select, write
//                           enable, instruction word)
//   dmem                  : data-memory bus (master side)
//   stall_mem             : freeze PC, IF/ID, ID/EXE and EX/MEM this cycle
//   *_MEM_WB              : registered write-back bundle
//   mem_err               : sticky flag for timeout or misaligned access
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          npc_EXE_MEM,
  input  logic [31:0]          c_EXE_MEM,
  input  logic [31:0]          b_EXE_MEM,
  input  logic [4:0]           num_write_EXE_MEM,
  input  logic                 mem_write_EXE_MEM,
  input  logic [1:0]           s_data_write_EXE_MEM,
  input  logic                 reg_write_EXE_MEM,
  input  logic [31:0]          ins_EXE_MEM,
  mem_wb_stage_if.master       dmem,
  output logic                 stall_mem,
  output logic [31:0]          data_MEM_WB,
  output logic [4:0]           num_write_MEM_WB,
  output logic                 reg_write_MEM_WB,
  output logic [31:0]          ins_MEM_WB,
  output logic                 mem_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  mem_state_t    state, state_next;
  logic [CW-1:0] count, count_next;
  logic          need_acc, aligned, misaligned, in_wait, timeout, done;
  logic          bubble;
  logic [31:0]   wb_value;
  mem_wb_t       wb_d, wb_q;

  assign need_acc   = mem_write_EXE_MEM | (s_data_write_EXE_MEM == WB_SEL_MEM);
  assign aligned    = (c_EXE_MEM[1:0] == 2'b00);
  assign misaligned = need_acc & ~aligned;
  assign in_wait    = (state == MEM_WAIT);
  assign timeout    = in_wait & (count == LAST_COUNT) & ~dmem.dmem_ack;
  assign done       = in_wait & (dmem.dmem_ack | timeout);

  // Released in the completing cycle so EX/MEM advances on the capture edge
  assign stall_mem = need_acc & aligned & ~done;

  // EX/MEM is frozen during WAIT, so these stay stable for the whole access
  assign dmem.dmem_req   = in_wait;
  assign dmem.dmem_we    = mem_write_EXE_MEM;
  assign dmem.dmem_addr  = {c_EXE_MEM[31:2], 2'b00};
  assign dmem.dmem_wdata = b_EXE_MEM;

  // Write-back source select; code 11 falls back to the ALU result
  always_comb begin
    wb_value = c_EXE_MEM;
    case (s_data_write_EXE_MEM)
      WB_SEL_MEM: wb_value = dmem.dmem_rdata;
      WB_SEL_NPC: wb_value = npc_EXE_MEM;
      default:    wb_value = c_EXE_MEM;
    endcase
  end

  // A memory instruction only reaches WB in the cycle its ack arrives
  assign bubble = misaligned | (need_acc & ~(in_wait & dmem.dmem_ack));

  assign wb_d = '{data:      wb_value,
                  num_write: num_write_EXE_MEM,
                  reg_write: reg_write_EXE_MEM,
                  ins:       ins_EXE_MEM};

  // Access FSM next state and wait counter
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      MEM_IDLE: begin
        count_next = '0;
        if (need_acc && aligned) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        count_next = count + CW'(1);
        if (done) begin
          state_next = MEM_IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = MEM_IDLE;
        count_next = '0;
      end
    endcase
  end

  // State, counter and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MEM_IDLE;
      count   <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      mem_err <= mem_err | misaligned | timeout;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clock  (clock),
    .reset  (reset),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign data_MEM_WB      = wb_q.data;
  assign num_write_MEM_WB = wb_q.num_write;
  assign reg_write_MEM_WB = wb_q.reg_write;
  assign ins_MEM_WB       = wb_q.ins;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: ALU pass-through, load with delayed
// ack, store with immediate ack, timeout, misaligned access and reset in
// the middle of a wait.
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic [31:0] npc_EXE_MEM, c_EXE_MEM, b_EXE_MEM, ins_EXE_MEM;
  logic [4:0]  num_write_EXE_MEM;
  logic        mem_write_EXE_MEM, reg_write_EXE_MEM;
  logic [1:0]  s_data_write_EXE_MEM;
  logic        stall_mem, reg_write_MEM_WB, mem_err;
  logic [31:0] data_MEM_WB, ins_MEM_WB;
  logic [4:0]  num_write_MEM_WB;

  int checks = 0;
  int errors = 0;

  mem_wb_stage_if dmem_bus ();

  mem_wb_stage #(.TIMEOUT(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .npc_EXE_MEM          (npc_EXE_MEM),
    .c_EXE_MEM            (c_EXE_MEM),
    .b_EXE_MEM            (b_EXE_MEM),
    .num_write_EXE_MEM    (num_write_EXE_MEM),
    .mem_write_EXE_MEM    (mem_write_EXE_MEM),
    .s_data_write_EXE_MEM (s_data_write_EXE_MEM),
    .reg_write_EXE_MEM    (reg_write_EXE_MEM),
    .ins_EXE_MEM          (ins_EXE_MEM),
    .dmem                 (dmem_bus),
    .stall_mem            (stall_mem),
    .data_MEM_WB          (data_MEM_WB),
    .num_write_MEM_WB     (num_write_MEM_WB),
    .reg_write_MEM_WB     (reg_write_MEM_WB),
    .ins_MEM_WB           (ins_MEM_WB),
    .mem_err              (mem_err)
  );

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One comparison: count it and report any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Load the EX/MEM register contents seen by the stage
  task automatic applyStimulus(input logic [31:0] npc, input logic [31:0] c,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic mw, input logic [1:0] sel,
                               input logic rw, input logic [31:0] ins);
    npc_EXE_MEM          = npc;
    c_EXE_MEM            = c;
    b_EXE_MEM            = b;
    num_write_EXE_MEM    = rd;
    mem_write_EXE_MEM    = mw;
    s_data_write_EXE_MEM = sel;
    reg_write_EXE_MEM    = rw;
    ins_EXE_MEM          = ins;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset state: everything registered is zero and nothing is requested
  task automatic checkCleared(input string tag);
    @(negedge clock);
    checkOutput({tag, "_data"}, data_MEM_WB, 32'h0);
    checkOutput({tag, "_num"},  {27'h0, num_write_MEM_WB}, 32'h0);
    checkOutput({tag, "_rw"},   {31'h0, reg_write_MEM_WB}, 32'h0);
    checkOutput({tag, "_ins"},  ins_MEM_WB, 32'h0);
    checkOutput({tag, "_err"},  {31'h0, mem_err}, 32'h0);
    checkOutput({tag, "_req"},  {31'h0, dmem_bus.dmem_req}, 32'h0);
    checkOutput({tag, "_stall"},{31'h0, stall_mem}, 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int  wait_cycles;
  logic last_stall;
  logic stall_at_15;

  initial begin
    reset = 1'b1;
    doReset();
    checkCleared("reset");

    // 1: ALU op passes straight through with one-cycle latency
    tick();
    applyStimulus(32'h8, 32'h10, 32'h0, 5'd5, 1'b0, 2'b00, 1'b1, 32'h00A00293);
    @(negedge clock);
    checkOutput("alu_stall", {31'h0, stall_mem}, 32'h0);
    checkOutput("alu_req",   {31'h0, dmem_bus.dmem_req}, 32'h0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    @(negedge clock);
    checkOutput("alu_data", data_MEM_WB, 32'h10);
    checkOutput("alu_num",  {27'h0, num_write_MEM_WB}, 32'd5);
    checkOutput("alu_rw",   {31'h0, reg_write_MEM_WB}, 32'h1);
    checkOutput("alu_ins",  ins_MEM_WB, 32'h00A00293);

    // 2: load, ack in the third WAIT cycle
    tick();
    applyStimulus(32'h20, 32'h100, 32'h0, 5'd7, 1'b0, 2'b01, 1'b1, 32'h10002383);
    @(negedge clock);
    checkOutput("ld_idle_stall", {31'h0, stall_mem}, 32'h1);
    checkOutput("ld_idle_req",   {31'h0, dmem_bus.dmem_req}, 32'h0);
    tick();
    @(negedge clock);
    checkOutput("ld_w1_req",   {31'h0, dmem_bus.dmem_req}, 32'h1);
    checkOutput("ld_w1_we",    {31'h0, dmem_bus.dmem_we}, 32'h0);
    checkOutput("ld_w1_addr",  dmem_bus.dmem_addr, 32'h100);
    checkOutput("ld_w1_stall", {31'h0, stall_mem}, 32'h1);
    checkOutput("ld_w1_bubble",{31'h0, reg_write_MEM_WB}, 32'h0);
    tick();
    @(negedge clock);
    checkOutput("ld_w2_stall", {31'h0, stall_mem}, 32'h1);
    checkOutput("ld_w2_data",  data_MEM_WB, 32'h0);
    tick();
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge clock);
    checkOutput("ld_w3_stall", {31'h0, stall_mem}, 32'h0);
    checkOutput("ld_w3_req",   {31'h0, dmem_bus.dmem_req}, 32'h1);
    tick();
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    @(negedge clock);
    checkOutput("ld_data", data_MEM_WB, 32'hCAFEF00D);
    checkOutput("ld_num",  {27'h0, num_write_MEM_WB}, 32'd7);
    checkOutput("ld_rw",   {31'h0, reg_write_MEM_WB}, 32'h1);
    checkOutput("ld_req",  {31'h0, dmem_bus.dmem_req}, 32'h0);

    // 3: store acknowledged in its first WAIT cycle
    tick();
    applyStimulus(32'h24, 32'h204, 32'h1234, 5'd0, 1'b1, 2'b00, 1'b0, 32'h20102223);
    @(negedge clock);
    checkOutput("st_stall0", {31'h0, stall_mem}, 32'h1);
    checkOutput("st_we",     {31'h0, dmem_bus.dmem_we}, 32'h1);
    checkOutput("st_wdata",  dmem_bus.dmem_wdata, 32'h1234);
    checkOutput("st_addr",   dmem_bus.dmem_addr, 32'h204);
    tick();
    dmem_bus.dmem_ack = 1'b1;
    @(negedge clock);
    checkOutput("st_stall1", {31'h0, stall_mem}, 32'h0);
    checkOutput("st_req",    {31'h0, dmem_bus.dmem_req}, 32'h1);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    @(negedge clock);
    checkOutput("st_rw",  {31'h0, reg_write_MEM_WB}, 32'h0);
    checkOutput("st_ins", ins_MEM_WB, 32'h20102223);
    checkOutput("st_err", {31'h0, mem_err}, 32'h0);

    // 4: load that is never acknowledged times out after 16 WAIT cycles
    tick();
    applyStimulus(32'h28, 32'h300, 32'h0, 5'd3, 1'b0, 2'b01, 1'b1, 32'h30002183);
    wait_cycles = 0;
    stall_at_15 = 1'b0;
    last_stall  = 1'b1;
    for (int i = 0; i < 40 && last_stall; i++) begin
      @(negedge clock);
      last_stall = stall_mem;
      if (dmem_bus.dmem_req) begin
        wait_cycles++;
        if (wait_cycles == 15) stall_at_15 = stall_mem;
      end
      tick();
      if (!last_stall) applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    end
    checkOutput("to_cycles",  wait_cycles, 32'd16);
    checkOutput("to_stall15", {31'h0, stall_at_15}, 32'h1);
    checkOutput("to_unstall", {31'h0, last_stall}, 32'h0);
    @(negedge clock);
    checkOutput("to_err",  {31'h0, mem_err}, 32'h1);
    checkOutput("to_req",  {31'h0, dmem_bus.dmem_req}, 32'h0);
    checkOutput("to_rw",   {31'h0, reg_write_MEM_WB}, 32'h0);
    checkOutput("to_data", data_MEM_WB, 32'h0);

    // 5: misaligned load, error flag cleared first so it must be set again
    doReset();
    checkCleared("rst2");
    tick();
    applyStimulus(32'h2C, 32'h102, 32'h0, 5'd9, 1'b0, 2'b01, 1'b1, 32'h10204483);
    @(negedge clock);
    checkOutput("mis_req",   {31'h0, dmem_bus.dmem_req}, 32'h0);
    checkOutput("mis_stall", {31'h0, stall_mem}, 32'h0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    @(negedge clock);
    checkOutput("mis_err", {31'h0, mem_err}, 32'h1);
    checkOutput("mis_rw",  {31'h0, reg_write_MEM_WB}, 32'h0);
    checkOutput("mis_num", {27'h0, num_write_MEM_WB}, 32'h0);
    checkOutput("mis_ins", ins_MEM_WB, 32'h0);
    checkOutput("mis_req2",{31'h0, dmem_bus.dmem_req}, 32'h0);

    // 6: reset during the second WAIT cycle, late ack must be ignored
    tick();
    applyStimulus(32'h30, 32'h400, 32'h0, 5'd4, 1'b0, 2'b01, 1'b1, 32'h40002203);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rw2_req", {31'h0, dmem_bus.dmem_req}, 32'h1);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b0, 2'b00, 1'b0, '0);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEADBEEF;
    checkCleared("mid_rst");
    tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("late_ack_req", {31'h0, dmem_bus.dmem_req}, 32'h0);
    tick();
    dmem_bus.dmem_ack = 1'b0;
    checkCleared("late_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
